// File: rtl/theta_pkg.sv
// Shared types, sizes and parity helpers for the theta column-mix stage.
package theta_pkg;

  localparam int unsigned LINE_W = 25;
  localparam int unsigned SLICES = 64;
  localparam int unsigned CNT_W  = 6;

  localparam logic [CNT_W-1:0] LastSlice = CNT_W'(SLICES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPre,
    StRun,
    StDone
  } theta_state_e;

  // Lane bit position inside a slice line: x selects column, y selects row.
  function automatic int bit_idx(input int x, input int y);
    return 5 * y + x;
  endfunction

  function automatic logic [4:0] col_par(input logic [LINE_W-1:0] line);
    logic [4:0] par;
    par = '0;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        par[x] = par[x] ^ line[bit_idx(x, y)];
      end
    end
    return par;
  endfunction

endpackage

// File: rtl/theta_slice_mix.sv
// Combinational mix of one slice line with its own column parities and the
// parities of the previous slice.
module theta_slice_mix
  import theta_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [4:0]        prev_par_i,
  output logic [LINE_W-1:0] mixed_o,
  output logic [4:0]        col_par_o
);

  logic [4:0] par;
  logic [4:0] d;

  always_comb begin
    par = col_par(line_i);
    d   = '0;
    // Column x takes parity of column x-1 in this slice and x+1 in the slice before.
    for (int x = 0; x < 5; x++) begin
      d[x] = par[(x + 4) % 5] ^ prev_par_i[(x + 1) % 5];
    end
    mixed_o = line_i;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        mixed_o[bit_idx(x, y)] = line_i[bit_idx(x, y)] ^ d[x];
      end
    end
  end

  assign col_par_o = par;

endmodule

// File: rtl/theta_apply_func.sv
// In-place theta column-parity mix over the 64-slice matrix memory.
// Optional THETA_CHECKSUM_EN adds an XOR checksum of all written lines.
module theta_apply_func
  import theta_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LINE_W-1:0] line_in,
  output logic [CNT_W-1:0]  cnt_value,
  output logic              write_enable,
  output logic [LINE_W-1:0] write_value,
  output logic              done
`ifdef THETA_CHECKSUM_EN
  ,
  output logic [LINE_W-1:0] checksum
`endif
);

  theta_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        prev_par_q, prev_par_d;
  logic [4:0]        cur_par;
  logic [LINE_W-1:0] mixed;

  theta_slice_mix u_slice_mix (
    .line_i     (line_in),
    .prev_par_i (prev_par_q),
    .mixed_o    (mixed),
    .col_par_o  (cur_par)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prev_par_d   = prev_par_q;
    write_enable = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Park on the last slice so PRE reads slice 63 before it is overwritten.
        cnt_d = LastSlice;
        if (start) begin
          state_d = StPre;
        end
      end
      StPre: begin
        prev_par_d = cur_par;
        cnt_d      = '0;
        state_d    = StRun;
      end
      StRun: begin
        write_enable = 1'b1;
        prev_par_d   = cur_par;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == LastSlice) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      prev_par_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_par_q <= prev_par_d;
    end
  end

  assign cnt_value   = cnt_q;
  assign write_value = mixed;

`ifdef THETA_CHECKSUM_EN
  logic [LINE_W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == StPre) begin
      checksum_d = '0;
    end else if (state_q == StRun) begin
      checksum_d = checksum_q ^ mixed;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_theta_apply_func.sv
// Scoreboard bench for theta_apply_func with a behavioural matrix memory.
module tb_theta_apply_func;
  import theta_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LINE_W-1:0] line_in;
  logic [CNT_W-1:0]  cnt_value;
  logic              write_enable;
  logic [LINE_W-1:0] write_value;
  logic              done;
`ifdef THETA_CHECKSUM_EN
  logic [LINE_W-1:0] checksum;
`endif

  logic [LINE_W-1:0] mem [SLICES];
  logic [LINE_W-1:0] got [SLICES];

  typedef struct packed {
    logic [CNT_W-1:0]  addr;
    logic [LINE_W-1:0] data;
  } wr_t;

  wr_t               exp_q[$];
  logic [LINE_W-1:0] exp_ck;
  int                checks = 0;
  int                failures = 0;
  int                n_wr;
  int                n_done;
  int                done_k;

  always #5 clk = ~clk;

  assign line_in = mem[cnt_value];

  theta_apply_func dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .line_in      (line_in),
    .cnt_value    (cnt_value),
    .write_enable (write_enable),
    .write_value  (write_value),
    .done         (done)
`ifdef THETA_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  function automatic logic [4:0] m_par(input logic [LINE_W-1:0] l);
    logic [4:0] c;
    c = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        c[x] = c[x] ^ l[5*y+x];
    return c;
  endfunction

  // line'[x,y] = line[x,y] ^ C[x-1][z] ^ C[x+1][z-1]
  function automatic logic [LINE_W-1:0] m_mix(input logic [LINE_W-1:0] l,
                                               input logic [4:0] cur, input logic [4:0] prv);
    logic [LINE_W-1:0] r;
    r = l;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[5*y+x] = l[5*y+x] ^ cur[(x+4)%5] ^ prv[(x+1)%5];
    return r;
  endfunction

  task automatic build_expected();
    wr_t e;
    exp_q.delete();
    exp_ck = '0;
    for (int z = 0; z < SLICES; z++) begin
      e.addr = z[CNT_W-1:0];
      e.data = m_mix(mem[z], m_par(mem[z]), m_par(mem[(z+SLICES-1)%SLICES]));
      exp_q.push_back(e);
      exp_ck = exp_ck ^ e.data;
    end
  endtask

  task automatic fill_zero();
    for (int i = 0; i < SLICES; i++) mem[i] = '0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < SLICES; i++) mem[i] = LINE_W'($urandom());
  endtask

  // Starts one sweep and acts as the memory: each DUT write is scored against
  // the model and committed to mem just after the clock edge it belongs to.
  task automatic run_sweep(input int rst_at, input int restart_at, input bit hold);
    wr_t               e;
    bit                pend;
    bit                stop;
    logic [CNT_W-1:0]  p_addr;
    logic [LINE_W-1:0] p_data;
    build_expected();
    n_wr = 0;
    n_done = 0;
    done_k = -1;
    stop = 1'b0;
    p_addr = '0;
    p_data = '0;
    for (int i = 0; i < SLICES; i++) got[i] = '0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 80 && !stop; k++) begin
      @(negedge clk);
      pend = 1'b0;
      if (!hold) start = 1'b0;
      if (k == 1) begin
        checks++;
        if (write_enable !== 1'b0 || cnt_value !== LastSlice) begin
          failures++;
          $display("FAIL pre_cycle we=%b cnt=%0d required we=0 cnt=63", write_enable, cnt_value);
        end
      end
      if (write_enable === 1'b1) begin
        n_wr++;
        pend = 1'b1;
        p_addr = cnt_value;
        p_data = write_value;
        got[cnt_value] = write_value;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL write_extra addr=%0d data=%h required no write", cnt_value, write_value);
        end else begin
          e = exp_q.pop_front();
          if (cnt_value !== e.addr || write_value !== e.data) begin
            failures++;
            $display("FAIL write addr=%0d data=%h required addr=%0d data=%h",
                     cnt_value, write_value, e.addr, e.data);
          end
        end
        if (restart_at == int'(cnt_value)) start = 1'b1;
        if (rst_at == int'(cnt_value)) begin
          rst = 1'b0;
          stop = 1'b1;
        end
      end
      if (done === 1'b1) begin
        n_done++;
        done_k = k;
        stop = 1'b1;
      end
      @(posedge clk);
      #1;
      if (pend) mem[p_addr] = p_data;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    fill_zero();
    repeat (2) @(negedge clk);
    checks++;
    if (write_enable !== 1'b0 || done !== 1'b0 || cnt_value !== '0) begin
      failures++;
      $display("FAIL reset we=%b done=%b cnt=%0d required 0 0 0", write_enable, done, cnt_value);
    end
`ifdef THETA_CHECKSUM_EN
    checks++;
    if (checksum !== '0) begin
      failures++;
      $display("FAIL reset_checksum got=%h required 0", checksum);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cnt_value !== LastSlice || write_enable !== 1'b0) begin
      failures++;
      $display("FAIL idle cnt=%0d we=%b required cnt=63 we=0", cnt_value, write_enable);
    end
  endtask

  task automatic test_zero();
    int nz;
    fill_zero();
    run_sweep(-1, -1, 1'b0);
    nz = 0;
    for (int i = 0; i < SLICES; i++) if (got[i] !== '0) nz++;
    checks++;
    if (n_wr != 64 || nz != 0) begin
      failures++;
      $display("FAIL zero_writes count=%0d nonzero=%0d required 64 0", n_wr, nz);
    end
    checks++;
    if (n_done != 1 || done_k != 66) begin
      failures++;
      $display("FAIL zero_done count=%0d at=%0d required 1 at 66", n_done, done_k);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse got=%b required 0", done);
    end
  endtask

  task automatic test_single_bit();
    int nz;
    fill_zero();
    mem[0] = 25'h1;
    run_sweep(-1, -1, 1'b0);
    checks++;
    if (got[0] !== 25'h0210843 || got[1] !== 25'h1084210) begin
      failures++;
      $display("FAIL single_bit s0=%h s1=%h required 0210843 1084210", got[0], got[1]);
    end
    nz = 0;
    for (int i = 2; i < SLICES; i++) if (got[i] !== '0) nz++;
    checks++;
    if (nz != 0 || n_wr != 64) begin
      failures++;
      $display("FAIL single_bit_rest nonzero=%0d writes=%0d required 0 64", nz, n_wr);
    end
  endtask

  task automatic test_wrap();
    int nz;
    fill_zero();
    mem[63] = 25'h1;
    run_sweep(-1, -1, 1'b0);
    checks++;
    if (got[0] !== 25'h1084210 || got[63] !== 25'h0210843) begin
      failures++;
      $display("FAIL wrap s0=%h s63=%h required 1084210 0210843", got[0], got[63]);
    end
    nz = 0;
    for (int i = 1; i < 63; i++) if (got[i] !== '0) nz++;
    checks++;
    if (nz != 0) begin
      failures++;
      $display("FAIL wrap_rest nonzero=%0d required 0", nz);
    end
  endtask

  task automatic test_restart();
    int extra;
    fill_random();
    run_sweep(-1, 10, 1'b0);
    checks++;
    if (n_wr != 64 || n_done != 1 || done_k != 66) begin
      failures++;
      $display("FAIL restart writes=%0d done=%0d at=%0d required 64 1 66", n_wr, n_done, done_k);
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0 || write_enable !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL restart_quiet active_cycles=%0d required 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    fill_random();
    run_sweep(20, -1, 1'b0);
    @(negedge clk);
    checks++;
    if (write_enable !== 1'b0 || done !== 1'b0 || cnt_value !== '0 || n_wr != 21) begin
      failures++;
      $display("FAIL reset_mid we=%b done=%b cnt=%0d writes=%0d required 0 0 0 21",
               write_enable, done, cnt_value, n_wr);
    end
    rst = 1'b1;
    run_sweep(-1, -1, 1'b0);
    checks++;
    if (n_wr != 64 || n_done != 1 || done_k != 66 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_resweep writes=%0d done=%0d at=%0d left=%0d required 64 1 66 0",
               n_wr, n_done, done_k, exp_q.size());
    end
  endtask

  task automatic test_start_held();
    fill_random();
    run_sweep(-1, -1, 1'b1);
    checks++;
    if (n_wr != 64 || done_k != 66) begin
      failures++;
      $display("FAIL held_sweep writes=%0d at=%0d required 64 66", n_wr, done_k);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (write_enable !== 1'b0 || cnt_value !== LastSlice) begin
      failures++;
      $display("FAIL held_pre we=%b cnt=%0d required 0 63", write_enable, cnt_value);
    end
    @(negedge clk);
    checks++;
    if (write_enable !== 1'b1 || cnt_value !== '0) begin
      failures++;
      $display("FAIL held_rerun we=%b cnt=%0d required 1 0", write_enable, cnt_value);
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_checksum();
`ifdef THETA_CHECKSUM_EN
    fill_random();
    run_sweep(-1, -1, 1'b0);
    @(negedge clk);
    checks++;
    if (checksum !== exp_ck) begin
      failures++;
      $display("FAIL checksum got=%h required %h", checksum, exp_ck);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (checksum !== exp_ck) begin
      failures++;
      $display("FAIL checksum_hold got=%h required %h", checksum, exp_ck);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_zero();
    test_single_bit();
    test_wrap();
    test_restart();
    test_reset_mid();
    test_start_held();
    test_checksum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
